gnt_pkt_mux: RTL and testbench
==============================

# gnt_pkt_mux

Packet-locking stream multiplexer that sits directly downstream of the round-robin arbiter. It presents per-source packet requests to the arbiter and consumes the one-hot grant. It holds the granted source for a whole multi-beat packet and forwards beats through a 2-entry output buffer onto a single valid/ready stream. Requests reach the arbiter only when a beat can actually be accepted, so the arbiter's priority rotates once per packet, not once per cycle.

## Interface
- NUM_REQ, 10, number of source streams; must be ≥ 2
- DATA_W, 32, beat payload width
- SRC_W, $clog2(NUM_REQ), width of the source index
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_REQ  per-source beat valid
- in_ready  out  NUM_REQ  per-source beat accept; combinational
- in_data  in  NUM_REQ*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W]
- in_last  in  NUM_REQ  per-source end-of-packet marker
- arb_req  out  NUM_REQ  request vector to the arbiter
- arb_gnt  in  NUM_REQ  one-hot grant from the arbiter, combinational from arb_req in the same cycle
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  output payload
- out_last  out  1  output end-of-packet
- out_src  out  SRC_W  source index of the current output beat
- gnt_err  out  1  sticky flag for a protocol violation on arb_gnt

## Operation
- **State machine:** IDLE / LOCKED, plus registers owner[SRC_W] and count[1:0] (output buffer occupancy, 0–2).
- **space:** space = (count < 2). It is based on the registered count only. A pop in the same cycle does not free space.
- **arb_req:** in_valid & {NUM_REQ{state==IDLE && space}}. It is all-zero in LOCKED or when the buffer is full.
- **IDLE:**
  - g = index of the set bit of arb_gnt & in_valid.
  - in_ready[g] = space; all other in_ready = 0.
  - On push: if in_last[g] = 1, stay IDLE; otherwise go to LOCKED with owner <= g.
- **LOCKED:**
  - in_ready[owner] = space; all others = 0. arb_gnt is ignored.
  - Each push of in_data[owner] is forwarded.
  - A push with in_last[owner] = 1 returns the block to IDLE.
  - in_valid[owner] low simply stalls. The lock is held indefinitely.
- **Pushed entry:** {data, last, src}. src = g in IDLE, owner in LOCKED.
- **Output buffer:**
  - 2-entry FIFO. The head drives out_data, out_last and out_src.
  - out_valid = (count != 0). Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- **Grant faults:**
  - If arb_gnt has more than one bit set, or any set bit where in_valid = 0, gnt_err is set and held until rst.
  - In both cases the block uses the lowest-index bit of arb_gnt & in_valid.
  - If that masked vector is zero, nothing is pushed.
- **arb_gnt != 0 while arb_req == 0:** sets gnt_err; no push.
- **Reset values:**
  - State IDLE, owner 0, count 0.
  - out_valid 0, out_data 0, out_last 0, out_src 0, gnt_err 0.
  - in_ready and arb_req are all-zero during reset.
- **Reset mid-packet or with a non-empty buffer:** the lock is dropped and buffered beats are discarded. There is no partial-packet recovery.

## Timing
- **Combinational paths:**
  - in_valid → arb_req → (arbiter) → arb_gnt → in_ready, within one cycle.
  - No path from out_ready to in_ready or arb_req.
- **Latency:** a beat accepted at edge N is visible on the out_* signals after edge N, so it can be popped at edge N+1 at the earliest.
- **Throughput:** 1 beat/cycle sustained while out_ready = 1 (count settles at 1). With out_ready = 0, the block accepts 2 beats and then stalls.
- **Packet boundaries:** no idle cycle is needed between the last beat of one packet and the first beat of the next packet. A new grant is taken in the cycle after the last beat.
- **Arbiter hand-off:** the arbiter sees arb_req != 0 only in cycles where a grant is consumed, so its grant vector is non-zero exactly once per packet.

## Test plan
- **Single-beat round robin:** sources 0, 3, 7 each hold a 1-beat packet, with out_ready = 1 → out_src sequence 0, 3, 7. One beat per cycle, first beat out 1 cycle after acceptance. gnt_err = 0.
- **Packet lock:**
  - Stimulus: source 2 sends a 4-beat packet (data 0xA0–0xA3) while source 5 keeps in_valid = 1.
  - Required: beats 0xA0–0xA3 are output contiguously with out_src = 2 and out_last only on 0xA3. arb_req = 0 during beats 2–4. Source 5's first beat follows immediately.
- **Backpressure:** out_ready = 0 for 6 cycles during a 5-beat packet → exactly 2 beats accepted, then in_ready = 0 and arb_req = 0. When out_ready rises, the remaining beats flow with no loss or reordering.
- **Owner stall:** in_valid[owner] drops for 3 cycles mid-packet while other sources request → no other source is granted. The packet resumes and completes.
- **Grant fault:** force arb_gnt = 0b0000_0110 with in_valid = 0b0000_0110 → gnt_err = 1, source 1 is granted, and gnt_err stays set until rst.
- **Reset mid-packet:** assert rst for 1 cycle after beat 2 of a 4-beat packet with count = 2 → next cycle out_valid = 0, state IDLE. A new packet from any source is arbitrated normally.

Source files
------------

// File: rtl/gnt_pkt_mux_if.sv
// Bundle of the source-side, arbiter-side and output-side signals of gnt_pkt_mux.
// The slave modport is the mux itself; master is whoever drives sources, grant and sink.
interface gnt_pkt_mux_if #(
    parameter int NUM_REQ = 10,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_last;
    logic [NUM_REQ-1:0]        arb_req;
    logic [NUM_REQ-1:0]        arb_gnt;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic [SRC_W-1:0]          out_src;
    logic                      gnt_err;

    modport master (
        output in_valid, in_data, in_last, arb_gnt, out_ready,
        input  in_ready, arb_req, out_valid, out_data, out_last, out_src, gnt_err
    );

    modport slave (
        input  in_valid, in_data, in_last, arb_gnt, out_ready,
        output in_ready, arb_req, out_valid, out_data, out_last, out_src, gnt_err
    );
endinterface

// File: rtl/gnt_pkt_mux.sv
// Packet-locking mux behind a round-robin arbiter: takes one grant per packet,
// holds that source until its last beat and forwards beats through a 2-entry FIFO.
module gnt_pkt_mux #(
    parameter int NUM_REQ = 10,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    gnt_pkt_mux_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             r_state, w_state_next;
    logic [SRC_W-1:0]   r_owner, w_owner_next;
    logic [1:0]         r_count;
    logic [DATA_W-1:0]  r_buf_data [2];
    logic               r_buf_last [2];
    logic [SRC_W-1:0]   r_buf_src  [2];
    logic               r_wptr, r_rptr;
    logic               r_gnt_err;

    logic [DATA_W-1:0]  w_in_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_req, w_gnt_m;
    logic [SRC_W-1:0]   w_gnt_idx, w_sel;
    logic               w_space, w_idle, w_gnt_any, w_sel_ok;
    logic               w_push, w_pop, w_push_last, w_fault;
    logic [DATA_W-1:0]  w_push_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign w_in_data[gi]   = bus.in_data[gi*DATA_W +: DATA_W];
            assign bus.in_ready[gi] = w_sel_ok && (w_sel == SRC_W'(gi));
        end
    endgenerate

    // Space looks only at the registered occupancy, so out_ready never reaches in_ready/arb_req.
    assign w_space = (r_count < 2'd2);
    assign w_idle  = (r_state == ST_IDLE);
    assign w_req   = bus.in_valid & {NUM_REQ{w_idle && w_space && !rst}};
    assign bus.arb_req = w_req;

    assign w_gnt_m   = bus.arb_gnt & w_req;
    assign w_gnt_any = |w_gnt_m;

    always_comb begin
        w_gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_gnt_m[i]) begin
                w_gnt_idx = SRC_W'(i);
            end
        end
    end

    assign w_sel       = w_idle ? w_gnt_idx : r_owner;
    assign w_sel_ok    = !rst && w_space && (w_idle ? w_gnt_any : 1'b1);
    assign w_push      = w_sel_ok && bus.in_valid[w_sel];
    assign w_push_data = w_in_data[w_sel];
    assign w_push_last = bus.in_last[w_sel];
    assign w_pop       = (r_count != 2'd0) && bus.out_ready;

    // Multi-hot grant, grant to a non-valid source, or any grant nobody asked for.
    assign w_fault = (|(bus.arb_gnt & (bus.arb_gnt - NUM_REQ'(1))))
                   || (|(bus.arb_gnt & ~bus.in_valid))
                   || ((|bus.arb_gnt) && !(|w_req));

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        if (w_push) begin
            if (w_push_last) begin
                w_state_next = ST_IDLE;
            end else begin
                w_state_next = ST_LOCKED;
                w_owner_next = w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_gnt_err <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_last[i] <= 1'b0;
                r_buf_src[i]  <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_owner   <= w_owner_next;
            r_gnt_err <= r_gnt_err | w_fault;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_buf_data[r_wptr] <= w_push_data;
                r_buf_last[r_wptr] <= w_push_last;
                r_buf_src[r_wptr]  <= w_sel;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_buf_data[r_rptr];
    assign bus.out_last  = r_buf_last[r_rptr];
    assign bus.out_src   = r_buf_src[r_rptr];
    assign bus.gnt_err   = r_gnt_err;
endmodule

// File: tb/tb_gnt_pkt_mux.sv
// Randomised bench for gnt_pkt_mux: per-source packet queues, a round-robin arbiter,
// a packet-level reference model feeding a scoreboard, and an independent output monitor.
module tb_gnt_pkt_mux;
    localparam int NR = 10;
    localparam int DW = 32;
    localparam int SW = $clog2(NR);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gnt_pkt_mux_if #(.NUM_REQ(NR), .DATA_W(DW), .SRC_W(SW)) bus ();
    gnt_pkt_mux #(.NUM_REQ(NR), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
    typedef struct packed {logic [DW-1:0] data; logic last; logic [SW-1:0] src;} exp_t;

    beat_t src_q [NR][$];
    exp_t  sb [$];
    int    n_cmp = 0;
    int    n_fail = 0;

    // reference state: packet lock, buffer occupancy, sticky fault
    bit    m_locked;
    int    m_owner;
    int    m_occ;
    bit    m_err;

    int             vprob = 100;
    int             rprob = 100;
    logic [NR-1:0]  en_mask = '1;
    logic [NR-1:0]  drop_mask = '0;
    logic           force_en = 1'b0;
    logic [NR-1:0]  force_val = '0;
    int             rr_ptr = 0;

    function automatic int lowest(logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [NR-1:0] rr_grant(logic [NR-1:0] req, int ptr);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (req[j]) return NR'(1) << j;
        end
        return '0;
    endfunction

    // Round-robin arbiter: combinational grant, priority moves past each consumed grant.
    always_comb bus.arb_gnt = force_en ? force_val : rr_grant(bus.arb_req, rr_ptr);
    always @(posedge clk) begin
        if (!force_en && bus.arb_gnt != '0) rr_ptr <= (lowest(bus.arb_gnt) + 1) % NR;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + DW'(k);
            b.last = (k == len - 1);
            src_q[src].push_back(b);
        end
    endtask

    task automatic model();
        logic [NR-1:0] exp_req, exp_ready, gnt, m;
        bit   space, acc, pop;
        int   sel;
        exp_t e;
        if (rst) begin
            chk("rst_arb_req", bus.arb_req, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            m_locked = 0; m_owner = 0; m_occ = 0; m_err = 0;
            sb.delete();
            return;
        end
        space   = (m_occ < 2);
        exp_req = (!m_locked && space) ? bus.in_valid : '0;
        gnt     = force_en ? force_val : rr_grant(exp_req, rr_ptr);
        m       = gnt & exp_req;
        if (m_locked) begin
            sel       = m_owner;
            acc       = space && bus.in_valid[sel];
            exp_ready = space ? (NR'(1) << sel) : '0;
        end else begin
            sel       = lowest(m);
            acc       = (m != '0);
            exp_ready = acc ? (NR'(1) << sel) : '0;
        end
        chk("arb_req", bus.arb_req, exp_req);
        chk("in_ready", bus.in_ready, exp_ready);
        chk("out_valid", bus.out_valid, m_occ != 0);
        chk("gnt_err", bus.gnt_err, m_err);
        pop = (m_occ != 0) && bus.out_ready;
        if ($countones(gnt) > 1 || (gnt & ~bus.in_valid) != '0 || (gnt != '0 && exp_req == '0))
            m_err = 1;
        if (acc) begin
            e.data = src_q[sel][0].data;
            e.last = src_q[sel][0].last;
            e.src  = SW'(sel);
            sb.push_back(e);
            void'(src_q[sel].pop_front());
            m_locked = !e.last;
            m_owner  = sel;
        end
        m_occ = m_occ + int'(acc) - int'(pop);
    endtask

    task automatic step(input bit do_rst, input logic [NR-1:0] fgnt);
        @(posedge clk);
        #1;
        rst       = do_rst;
        force_en  = (fgnt != '0);
        force_val = fgnt;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                bus.in_valid[i] = en_mask[i] && !drop_mask[i] && ($urandom_range(99) < vprob);
                bus.in_data[i*DW +: DW] = src_q[i][0].data;
                bus.in_last[i] = src_q[i][0].last;
            end else begin
                bus.in_valid[i] = 1'b0;
                bus.in_data[i*DW +: DW] = '0;
                bus.in_last[i] = 1'b0;
            end
        end
        bus.out_ready = !do_rst && ($urandom_range(99) < rprob);
        @(negedge clk);
        model();
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (src_q[i].size() > 0) return 1;
        return m_occ != 0;
    endfunction

    task automatic drain(input int limit);
        int c = 0;
        while (pending() && c < limit) begin
            step(0, '0);
            c++;
        end
        chk("drain_timeout", c >= limit, 0);
    endtask

    task automatic rst_check();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_src", bus.out_src, 0);
        chk("rst_gnt_err", bus.gnt_err, 0);
    endtask

    // Output monitor: pops the scoreboard whenever a beat leaves the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_underflow: got beat %0h src %0d, expected none", bus.out_data, bus.out_src);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                    chk("out_src", bus.out_src, e.src);
                    $display("beat data=%08h last=%0d src=%0d", bus.out_data, bus.out_last, bus.out_src);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.in_last = '0;
        bus.out_ready = 1'b0;
        step(1, '0);
        step(1, '0);
        step(0, '0);
        rst_check();

        // single-beat packets from 0, 3, 7
        add_pkt(0, 1, 32'h0000_0010);
        add_pkt(3, 1, 32'h0000_0013);
        add_pkt(7, 1, 32'h0000_0017);
        drain(200);

        // packet lock: 4-beat packet from 2 while 5 waits
        add_pkt(2, 4, 32'h0000_00A0);
        add_pkt(5, 2, 32'h0000_00B0);
        drain(200);

        // backpressure: output stalled for 6 cycles during a 5-beat packet
        add_pkt(4, 5, 32'h0000_00C0);
        rprob = 0;
        repeat (6) step(0, '0);
        chk("bp_in_ready", bus.in_ready, 0);
        rprob = 100;
        drain(200);

        // owner stall: owner drops valid for 3 cycles while others request
        add_pkt(6, 5, 32'h0000_00D0);
        add_pkt(1, 2, 32'h0000_00D8);
        add_pkt(8, 2, 32'h0000_00DC);
        repeat (2) step(0, '0);
        drop_mask = m_locked ? (NR'(1) << m_owner) : '0;
        repeat (3) step(0, '0);
        drop_mask = '0;
        drain(200);

        // grant fault: two-hot grant over two valid sources
        en_mask = NR'(10'b00_0000_0110);
        add_pkt(1, 1, 32'h0000_00E1);
        add_pkt(2, 1, 32'h0000_00E2);
        step(0, NR'(10'b00_0000_0110));
        step(0, '0);
        chk("gnt_err_set", bus.gnt_err, 1);
        en_mask = '1;
        drain(200);
        repeat (3) step(0, '0);
        chk("gnt_err_sticky", bus.gnt_err, 1);

        // reset with a half-sent packet and a full buffer
        add_pkt(3, 4, 32'h0000_00F0);
        rprob = 0;
        repeat (3) step(0, '0);
        step(1, '0);
        step(0, '0);
        rst_check();
        rprob = 100;
        add_pkt(9, 2, 32'h0000_0090);
        drain(300);

        // random traffic
        vprob = 70;
        rprob = 60;
        for (int p = 0; p < 40; p++) begin
            add_pkt($urandom_range(NR - 1), $urandom_range(4, 1), $urandom);
        end
        drain(4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
